pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter ARCH_BITS, default 32, datapath width.
REQ-002 SHALL have parameter REG_BITS, default 5, register-index width (register 0 hardwired zero).
REQ-003 SHALL have parameter DEPTH, default 3, in-flight stages tracked after decode (index 0 = ALU, 1 = DCache, 2 = WB).
REQ-004 SHALL have parameter LOAD_READY, default 2, MUL_READY, default 1, first stage index where load/mul results are forwardable; other writers ready at 0.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have dec_valid in 1, decode holds a real instruction; dec_src1/dec_src2 in REG_BITS, sources; dec_src1_used/dec_src2_used in 1, source read.
REQ-007 SHALL have dec_dst in REG_BITS, destination; dec_wen in 1, writes register; dec_is_load in 1; dec_is_mul in 1.
REQ-008 SHALL have rf_data1/rf_data2 in ARCH_BITS, register-file reads; stage_result in DEPTH*ARCH_BITS, result per stage (slice k = stage k).
REQ-009 SHALL have mem_stall in 1, DCache miss stall; branch_taken in 1, branch resolved taken in ALU.
REQ-010 SHALL have fwd_data1/fwd_data2 out ARCH_BITS, operands; stall_decode out 1, hold fetch/decode; flush_decode out 1, squash decode; issue out 1, decode instruction enters ALU.
REQ-011 SHALL have stall_count out 32, fwd_count out 32, saturating performance counters.

Function
REQ-012 Scoreboard SHALL hold DEPTH entries {valid, dst, ready_idx}; ready_idx = LOAD_READY if load, MUL_READY if mul, else 0.
REQ-013 Match on source s at entry k SHALL require valid, s != 0, dst == s, used flag set; youngest (lowest k) match wins.
REQ-014 Youngest match with k >= ready_idx SHALL forward stage_result slice k; no match SHALL pass rf_data; source 0 SHALL output 0.
REQ-015 Youngest match with k < ready_idx SHALL raise hazard; stall_decode = dec_valid & hazard & !branch_taken, or mem_stall.
REQ-016 flush_decode SHALL equal branch_taken & !mem_stall.
REQ-017 issue SHALL equal dec_valid & dec_wen-agnostic & !stall_decode & !flush_decode.
REQ-018 Outputs REQ-014..017 SHALL be combinational (zero-cycle) from inputs and scoreboard.
REQ-019 On clk edge with mem_stall = 1, all entries SHALL hold unchanged.
REQ-020 Otherwise entries SHALL shift (k <- k-1); entry 0 SHALL load {dec_wen, dec_dst, ready_idx} if issue, else a bubble (valid = 0); entry DEPTH-1 retires.
REQ-021 mem_stall SHALL take priority over branch_taken and hazard; branch_taken SHALL take priority over hazard.
REQ-022 stall_count SHALL increment each cycle stall_decode = 1; fwd_count SHALL increment by 1 per cycle with issue = 1 and any forwarded source; both SHALL saturate at 32'hFFFFFFFF.
REQ-023 dec_wen = 1 with dec_dst = 0 SHALL enter as valid = 0.

Reset
REQ-024 rst asserted SHALL immediately clear all entry valid bits and both counters regardless of clk; stall_decode, flush_decode, issue SHALL read 0 while rst = 1.
REQ-025 rst asserted mid-stall SHALL abandon the stall; first edge after release SHALL behave as an empty scoreboard.

Structure
REQ-026 Opcode constants, NOP encoding and default parameter values SHALL live in the shared package proc_pkg.
REQ-027 Per-source match/forward logic SHALL be one sub-module hazard_src_match, instantiated twice.
REQ-028 Scoreboard and counters SHALL remain in pipe_hazard_unit.

Verification
REQ-029 ADD r3 issued, next cycle ADD r4,r3,r3 -> fwd_data1 = fwd_data2 = stage_result[0], no stall, fwd_count = 1.
REQ-030 LDW r5 issued, next ADD r6,r5,r1 -> stall_decode = 1 two cycles, then forward slice 2; stall_count = 2.
REQ-031 LDW r5 at entry 0 with mem_stall = 1 five cycles -> entries frozen, stall_decode = 1 five cycles, no shift.
REQ-032 branch_taken = 1 while decode has hazard on r5 -> flush_decode = 1, stall_decode = 0, entry 0 bubble next cycle.
REQ-033 ADD r0 issued, next reads r0 -> no stall, fwd_data = 0; rst pulsed between cycles mid-stall -> counters 0, no stall after release.

Source files
------------

// File: rtl/proc_pkg.sv
//==============================================================================
// Module   : proc_pkg
// Purpose  : Processor-wide shared definitions: opcode constants, the NOP
//            encoding, default datapath/pipeline parameters, and the helper that
//            maps a writer class to the first stage where its result can be
//            forwarded.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package proc_pkg;

    // Default datapath / pipeline shape
    localparam int unsigned c_ARCH_BITS_DEF  = 32;
    localparam int unsigned c_REG_BITS_DEF   = 5;
    localparam int unsigned c_DEPTH_DEF      = 3;   // 0 = ALU, 1 = DCache, 2 = WB
    localparam int unsigned c_LOAD_READY_DEF = 2;
    localparam int unsigned c_MUL_READY_DEF  = 1;

    // Major opcodes (RV32-style encoding)
    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_ALUI   = 7'h13,
        OP_STORE  = 7'h23,
        OP_ALU    = 7'h33,
        OP_BRANCH = 7'h63
    } opcode_e;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;

    // Class of a register writer, which decides its result latency
    typedef enum logic [1:0] {
        WR_ALU  = 2'd0,
        WR_MUL  = 2'd1,
        WR_LOAD = 2'd2
    } wrClass_e;

    // Load wins if both flags are set: its data arrives last.
    function automatic wrClass_e wrClassOf(input logic isLoad, input logic isMul);
        if (isLoad)
            return WR_LOAD;
        else if (isMul)
            return WR_MUL;
        return WR_ALU;
    endfunction

    function automatic int unsigned readyStageOf(input wrClass_e cls,
                                                 input int unsigned loadReady,
                                                 input int unsigned mulReady);
        case (cls)
            WR_LOAD: return loadReady;
            WR_MUL:  return mulReady;
            default: return 0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_unit_if.sv
//==============================================================================
// Module   : pipe_hazard_unit_if
// Purpose  : Bundle between the decode stage / pipeline datapath and the hazard
//            unit.
//   master : decode side - drives decode fields, RF reads, stage results,
//            mem_stall, branch_taken; receives operands and control.
//   slave  : hazard unit - the reverse, plus the two performance counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pipe_hazard_unit_if #(
    parameter int unsigned ARCH_BITS = proc_pkg::c_ARCH_BITS_DEF,
    parameter int unsigned REG_BITS  = proc_pkg::c_REG_BITS_DEF,
    parameter int unsigned DEPTH     = proc_pkg::c_DEPTH_DEF
) ();

    // Decode stage
    logic                       dec_valid;
    logic [REG_BITS-1:0]        dec_src1;
    logic [REG_BITS-1:0]        dec_src2;
    logic                       dec_src1_used;
    logic                       dec_src2_used;
    logic [REG_BITS-1:0]        dec_dst;
    logic                       dec_wen;
    logic                       dec_is_load;
    logic                       dec_is_mul;

    // Datapath
    logic [ARCH_BITS-1:0]       rf_data1;
    logic [ARCH_BITS-1:0]       rf_data2;
    logic [DEPTH*ARCH_BITS-1:0] stage_result;
    logic                       mem_stall;
    logic                       branch_taken;

    // Results
    logic [ARCH_BITS-1:0]       fwd_data1;
    logic [ARCH_BITS-1:0]       fwd_data2;
    logic                       stall_decode;
    logic                       flush_decode;
    logic                       issue;
    logic [31:0]                stall_count;
    logic [31:0]                fwd_count;

    modport master (
        output dec_valid, dec_src1, dec_src2, dec_src1_used, dec_src2_used,
               dec_dst, dec_wen, dec_is_load, dec_is_mul,
               rf_data1, rf_data2, stage_result, mem_stall, branch_taken,
        input  fwd_data1, fwd_data2, stall_decode, flush_decode, issue,
               stall_count, fwd_count
    );

    modport slave (
        input  dec_valid, dec_src1, dec_src2, dec_src1_used, dec_src2_used,
               dec_dst, dec_wen, dec_is_load, dec_is_mul,
               rf_data1, rf_data2, stage_result, mem_stall, branch_taken,
        output fwd_data1, fwd_data2, stall_decode, flush_decode, issue,
               stall_count, fwd_count
    );

endinterface

`default_nettype wire

// File: rtl/hazard_src_match.sv
//==============================================================================
// Module   : hazard_src_match
// Purpose  : Operand resolution for one decode source against the in-flight
//            scoreboard. Finds the youngest in-flight writer of the source and
//            either forwards its stage result (if already produced) or flags a
//            hazard. Register 0 always resolves to zero.
// Ports    : i_src/i_used      - source index and "source is read" flag
//            i_sb*             - scoreboard valid/dst/ready-stage per entry
//            i_stageResult     - per-stage result bus (slice k = stage k)
//            i_rfData          - register-file read for this source
//            o_fwdData         - resolved operand
//            o_hazard          - youngest writer has not produced its result
//            o_forwarded       - operand was taken from a pipeline stage
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_src_match #(
    parameter int unsigned ARCH_BITS = 32,
    parameter int unsigned REG_BITS  = 5,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned RDY_W     = 2
) (
    input  logic [REG_BITS-1:0]             i_src,
    input  logic                            i_used,
    input  logic [DEPTH-1:0]                i_sbValid,
    input  logic [DEPTH-1:0][REG_BITS-1:0]  i_sbDst,
    input  logic [DEPTH-1:0][RDY_W-1:0]     i_sbReady,
    input  logic [DEPTH*ARCH_BITS-1:0]      i_stageResult,
    input  logic [ARCH_BITS-1:0]            i_rfData,
    output logic [ARCH_BITS-1:0]            o_fwdData,
    output logic                            o_hazard,
    output logic                            o_forwarded
);

    logic [DEPTH-1:0] w_match;
    logic             w_hit;
    int               w_hitIdx;
    int               w_hitReady;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_match
            assign w_match[k] = i_sbValid[k] && i_used && (i_src != '0) &&
                                (i_sbDst[k] == i_src);
        end
    endgenerate

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        w_hit      = 1'b0;
        w_hitIdx   = 0;
        w_hitReady = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit      = 1'b1;
                w_hitIdx   = k;
                w_hitReady = int'(i_sbReady[k]);
            end
        end
    end

    // An older, ready writer of the same register is stale data, so only the
    // youngest match is considered even when it is not ready yet.
    always_comb begin
        o_fwdData   = i_rfData;
        o_hazard    = 1'b0;
        o_forwarded = 1'b0;
        if (i_src == '0) begin
            o_fwdData = '0;
        end else if (w_hit) begin
            if (w_hitIdx >= w_hitReady) begin
                o_fwdData   = i_stageResult[w_hitIdx*ARCH_BITS +: ARCH_BITS];
                o_forwarded = 1'b1;
            end else begin
                o_hazard = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
//==============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Data-hazard detection and operand forwarding for an in-order
//            pipeline. Tracks DEPTH in-flight writers after decode in a
//            shifting scoreboard, resolves both decode operands, and produces
//            stall / flush / issue control plus saturating stall and forward
//            performance counters.
// Ports    : clk  - clock
//            rst  - asynchronous, active-high reset
//            bus  - pipe_hazard_unit_if.slave (decode fields, RF reads, stage
//                   results, mem_stall, branch_taken; operands, control,
//                   counters)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_hazard_unit
    import proc_pkg::*;
#(
    parameter int unsigned ARCH_BITS  = c_ARCH_BITS_DEF,
    parameter int unsigned REG_BITS   = c_REG_BITS_DEF,
    parameter int unsigned DEPTH      = c_DEPTH_DEF,
    parameter int unsigned LOAD_READY = c_LOAD_READY_DEF,
    parameter int unsigned MUL_READY  = c_MUL_READY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave bus
);

    // Ready stage may equal DEPTH (never forwardable), hence DEPTH+1 codes.
    localparam int unsigned c_RDY_W   = $clog2(DEPTH + 1);
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    // Scoreboard: entry 0 is the instruction in ALU, DEPTH-1 the oldest.
    logic [DEPTH-1:0]               r_sbValid;
    logic [DEPTH-1:0][REG_BITS-1:0] r_sbDst;
    logic [DEPTH-1:0][c_RDY_W-1:0]  r_sbReady;

    logic [31:0] r_stallCount;
    logic [31:0] r_fwdCount;

    logic               w_hazard1;
    logic               w_hazard2;
    logic               w_fwd1;
    logic               w_fwd2;
    logic               w_stall;
    logic               w_flush;
    logic               w_issue;
    logic               w_enterValid;
    logic [c_RDY_W-1:0] w_decReady;

    //--------------------------------------------------------------------------
    // Operand resolution
    //--------------------------------------------------------------------------
    hazard_src_match #(
        .ARCH_BITS (ARCH_BITS),
        .REG_BITS  (REG_BITS),
        .DEPTH     (DEPTH),
        .RDY_W     (c_RDY_W)
    ) u_src1 (
        .i_src         (bus.dec_src1),
        .i_used        (bus.dec_src1_used),
        .i_sbValid     (r_sbValid),
        .i_sbDst       (r_sbDst),
        .i_sbReady     (r_sbReady),
        .i_stageResult (bus.stage_result),
        .i_rfData      (bus.rf_data1),
        .o_fwdData     (bus.fwd_data1),
        .o_hazard      (w_hazard1),
        .o_forwarded   (w_fwd1)
    );

    hazard_src_match #(
        .ARCH_BITS (ARCH_BITS),
        .REG_BITS  (REG_BITS),
        .DEPTH     (DEPTH),
        .RDY_W     (c_RDY_W)
    ) u_src2 (
        .i_src         (bus.dec_src2),
        .i_used        (bus.dec_src2_used),
        .i_sbValid     (r_sbValid),
        .i_sbDst       (r_sbDst),
        .i_sbReady     (r_sbReady),
        .i_stageResult (bus.stage_result),
        .i_rfData      (bus.rf_data2),
        .o_fwdData     (bus.fwd_data2),
        .o_hazard      (w_hazard2),
        .o_forwarded   (w_fwd2)
    );

    //--------------------------------------------------------------------------
    // Pipeline control
    //--------------------------------------------------------------------------
    // mem_stall freezes everything; a taken branch squashes decode, so a hazard
    // on the squashed instruction must not stall. Reset forces all three low.
    assign w_stall = ~rst & ((bus.dec_valid & (w_hazard1 | w_hazard2) &
                              ~bus.branch_taken) | bus.mem_stall);
    assign w_flush = ~rst & bus.branch_taken & ~bus.mem_stall;
    assign w_issue = ~rst & bus.dec_valid & ~w_stall & ~w_flush;

    assign bus.stall_decode = w_stall;
    assign bus.flush_decode = w_flush;
    assign bus.issue        = w_issue;

    // Writes to r0 are discarded, so they never enter as a live writer.
    assign w_enterValid = w_issue & bus.dec_wen & (bus.dec_dst != '0);
    assign w_decReady   = c_RDY_W'(readyStageOf(wrClassOf(bus.dec_is_load, bus.dec_is_mul),
                                                LOAD_READY, MUL_READY));

    //--------------------------------------------------------------------------
    // Scoreboard shift register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sbValid <= '0;
            r_sbDst   <= '0;
            r_sbReady <= '0;
        end else if (!bus.mem_stall) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_sbValid[k] <= r_sbValid[k-1];
                r_sbDst[k]   <= r_sbDst[k-1];
                r_sbReady[k] <= r_sbReady[k-1];
            end
            r_sbValid[0] <= w_enterValid;
            r_sbDst[0]   <= w_enterValid ? bus.dec_dst : '0;
            r_sbReady[0] <= w_enterValid ? w_decReady  : '0;
        end
    end

    //--------------------------------------------------------------------------
    // Saturating performance counters
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCount <= '0;
            r_fwdCount   <= '0;
        end else begin
            if (w_stall && (r_stallCount != c_CNT_MAX))
                r_stallCount <= r_stallCount + 32'd1;
            if (w_issue && (w_fwd1 || w_fwd2) && (r_fwdCount != c_CNT_MAX))
                r_fwdCount <= r_fwdCount + 32'd1;
        end
    end

    assign bus.stall_count = r_stallCount;
    assign bus.fwd_count   = r_fwdCount;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
//==============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Self-checking bench for pipe_hazard_unit. Directed scenarios for
//            the back-to-back ALU, load-use, memory stall, branch flush and r0
//            / mid-stall reset cases, followed by randomized traffic. Expected
//            values come from a queue-based model of the in-flight instructions.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_hazard_unit;

    localparam int c_AB = 32;
    localparam int c_RB = 5;
    localparam int c_DEPTH = 3;
    localparam int c_LOAD_RDY = 2;
    localparam int c_MUL_RDY = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.ARCH_BITS(c_AB), .REG_BITS(c_RB), .DEPTH(c_DEPTH)) bus ();

    pipe_hazard_unit #(
        .ARCH_BITS  (c_AB),
        .REG_BITS   (c_RB),
        .DEPTH      (c_DEPTH),
        .LOAD_READY (c_LOAD_RDY),
        .MUL_READY  (c_MUL_RDY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // In-flight instruction model: pipeQ[0] is the youngest (in ALU).
    typedef struct {
        bit valid;
        int dst;
        int rdy;
    } ent_t;

    ent_t        pipeQ[$];
    logic [31:0] stageRes [c_DEPTH];
    logic [31:0] mStall;
    logic [31:0] mFwd;
    int          nChecks;
    int          nFails;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        ent_t e;
        e.valid = 0; e.dst = 0; e.rdy = 0;
        pipeQ = {};
        for (int k = 0; k < c_DEPTH; k++) pipeQ.push_back(e);
        mStall = 0;
        mFwd   = 0;
    endtask

    task automatic randData();
        bus.rf_data1 = $urandom;
        bus.rf_data2 = $urandom;
        for (int k = 0; k < c_DEPTH; k++) begin
            stageRes[k] = $urandom;
            bus.stage_result[k*c_AB +: c_AB] = stageRes[k];
        end
    endtask

    // Drive one decode cycle at the falling edge. cls: 0 ALU, 1 MUL, 2 LOAD.
    task automatic cyc(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int dst, input bit wen, input int cls, input bit ms, input bit br);
        @(negedge clk);
        bus.dec_valid     = v;
        bus.dec_src1      = c_RB'(s1);
        bus.dec_src1_used = u1;
        bus.dec_src2      = c_RB'(s2);
        bus.dec_src2_used = u2;
        bus.dec_dst       = c_RB'(dst);
        bus.dec_wen       = wen;
        bus.dec_is_mul    = (cls == 1);
        bus.dec_is_load   = (cls == 2);
        bus.mem_stall     = ms;
        bus.branch_taken  = br;
        randData();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Resolve one source: find the youngest in-flight writer of s; its result
    // exists once its age (queue position) reaches its ready stage.
    task automatic refSrc(input int s, input bit u, input logic [31:0] rf,
                          output logic [31:0] d, output bit haz, output bit fw);
        bit done = 0;
        d = rf; haz = 0; fw = 0;
        if (s == 0) d = 0;
        else if (u) begin
            for (int k = 0; k < pipeQ.size(); k++) begin
                if (!done && pipeQ[k].valid && pipeQ[k].dst == s) begin
                    done = 1;
                    if (k >= pipeQ[k].rdy) begin d = stageRes[k]; fw = 1; end
                    else haz = 1;
                end
            end
        end
    endtask

    // Compare everything for the current cycle, then advance the model over
    // the next rising edge.
    task automatic evalCycle(input string tag);
        logic [31:0] d1, d2;
        bit h1, h2, f1, f2, eStall, eFlush, eIssue, ms, wen, ld, mul;
        int dst;
        ent_t e;
        #1;
        refSrc(int'(bus.dec_src1), bus.dec_src1_used, bus.rf_data1, d1, h1, f1);
        refSrc(int'(bus.dec_src2), bus.dec_src2_used, bus.rf_data2, d2, h2, f2);
        ms     = bus.mem_stall;
        eStall = (bus.dec_valid && (h1 || h2) && !bus.branch_taken) || ms;
        eFlush = bus.branch_taken && !ms;
        eIssue = bus.dec_valid && !eStall && !eFlush;
        checkVal({tag, ".stall"}, 32'(bus.stall_decode), 32'(eStall));
        checkVal({tag, ".flush"}, 32'(bus.flush_decode), 32'(eFlush));
        checkVal({tag, ".issue"}, 32'(bus.issue), 32'(eIssue));
        if (!h1) checkVal({tag, ".fwd1"}, bus.fwd_data1, d1);
        if (!h2) checkVal({tag, ".fwd2"}, bus.fwd_data2, d2);
        checkVal({tag, ".stallCnt"}, bus.stall_count, mStall);
        checkVal({tag, ".fwdCnt"}, bus.fwd_count, mFwd);
        wen = bus.dec_wen; ld = bus.dec_is_load; mul = bus.dec_is_mul;
        dst = int'(bus.dec_dst);
        @(posedge clk);
        if (eStall && mStall != 32'hFFFF_FFFF) mStall++;
        if (eIssue && (f1 || f2) && mFwd != 32'hFFFF_FFFF) mFwd++;
        if (!ms) begin
            e.valid = eIssue && wen && (dst != 0);
            e.dst   = dst;
            e.rdy   = ld ? c_LOAD_RDY : (mul ? c_MUL_RDY : 0);
            void'(pipeQ.pop_back());
            pipeQ.push_front(e);
        end
    endtask

    // Asynchronous reset pulse inside the low clock phase (called right
    // after cyc); control outputs and counters must be zero while asserted.
    task automatic applyReset();
        #1 rst = 1'b1;
        #1;
        checkVal("rst.stall", 32'(bus.stall_decode), 0);
        checkVal("rst.flush", 32'(bus.flush_decode), 0);
        checkVal("rst.issue", 32'(bus.issue), 0);
        checkVal("rst.stallCnt", bus.stall_count, 0);
        checkVal("rst.fwdCnt", bus.fwd_count, 0);
        rst = 1'b0;
        resetModel();
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst     = 1'b1;
        resetModel();
        // Hazard-provoking inputs held during reset: outputs still forced low.
        cyc(1, 1, 1, 2, 1, 3, 1, 0, 1, 1);
        applyReset();
        evalCycle("init");

        // Back-to-back ALU dependency forwards from stage 0.
        idle(); applyReset(); evalCycle("r29.0");
        cyc(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); evalCycle("r29.1");
        cyc(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
        #1;
        checkVal("r29.fwd1", bus.fwd_data1, stageRes[0]);
        checkVal("r29.fwd2", bus.fwd_data2, stageRes[0]);
        checkVal("r29.stall", 32'(bus.stall_decode), 0);
        evalCycle("r29.2");
        idle(); #1 checkVal("r29.fwdCnt", bus.fwd_count, 1); evalCycle("r29.3");

        // Load-use: two stall cycles, then forward from stage 2.
        idle(); applyReset(); evalCycle("r30.0");
        cyc(1, 1, 1, 2, 1, 5, 1, 2, 0, 0); evalCycle("r30.ld");
        for (int i = 0; i < 2; i++) begin
            cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
            #1 checkVal("r30.stall", 32'(bus.stall_decode), 1);
            evalCycle("r30.s");
        end
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        #1;
        checkVal("r30.go", 32'(bus.stall_decode), 0);
        checkVal("r30.fwd1", bus.fwd_data1, stageRes[2]);
        checkVal("r30.stallCnt", bus.stall_count, 2);
        evalCycle("r30.i");

        // mem_stall freezes the load in entry 0 for five cycles.
        idle(); applyReset(); evalCycle("r31.0");
        cyc(1, 1, 1, 2, 1, 5, 1, 2, 0, 0); evalCycle("r31.ld");
        for (int i = 0; i < 5; i++) begin
            cyc(1, 5, 1, 1, 1, 6, 1, 0, 1, 0);
            #1 checkVal("r31.stall", 32'(bus.stall_decode), 1);
            evalCycle("r31.ms");
        end
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        #1;
        checkVal("r31.held", 32'(bus.stall_decode), 1);
        checkVal("r31.stallCnt", bus.stall_count, 5);
        evalCycle("r31.a");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); evalCycle("r31.b");
        end

        // Taken branch squashes a hazarding decode; a bubble enters.
        idle(); applyReset(); evalCycle("r32.0");
        cyc(1, 1, 1, 2, 1, 5, 1, 2, 0, 0); evalCycle("r32.ld");
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
        #1;
        checkVal("r32.flush", 32'(bus.flush_decode), 1);
        checkVal("r32.stall", 32'(bus.stall_decode), 0);
        checkVal("r32.issue", 32'(bus.issue), 0);
        evalCycle("r32.br");
        cyc(1, 6, 1, 0, 1, 7, 1, 0, 0, 0);
        #1;
        checkVal("r32.bubble", bus.fwd_data1, bus.rf_data1);
        checkVal("r32.r0", bus.fwd_data2, 0);
        checkVal("r32.nostall", 32'(bus.stall_decode), 0);
        evalCycle("r32.n");

        // Write to r0 is not a hazard; reset mid-stall abandons the stall.
        idle(); applyReset(); evalCycle("r33.0");
        cyc(1, 1, 1, 2, 1, 0, 1, 2, 0, 0); evalCycle("r33.w0");
        cyc(1, 0, 1, 0, 1, 7, 1, 0, 0, 0);
        #1;
        checkVal("r33.fwd1", bus.fwd_data1, 0);
        checkVal("r33.fwd2", bus.fwd_data2, 0);
        checkVal("r33.stall", 32'(bus.stall_decode), 0);
        evalCycle("r33.rd");
        cyc(1, 1, 1, 2, 1, 5, 1, 2, 0, 0); evalCycle("r33.ld");
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        #1 checkVal("r33.stall1", 32'(bus.stall_decode), 1);
        evalCycle("r33.s");
        cyc(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        applyReset();
        #1;
        checkVal("r33.after", 32'(bus.stall_decode), 0);
        checkVal("r33.issue", 32'(bus.issue), 1);
        checkVal("r33.stallCnt", bus.stall_count, 0);
        evalCycle("r33.rel");

        // Randomized traffic on a small register range to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 4), $urandom_range(0, 3) != 0,
                $urandom_range(0, 4), $urandom_range(0, 3) != 0,
                $urandom_range(0, 4), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2),
                $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) applyReset();
            evalCycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
